// File: rtl/pe_array_pkg.sv
// Shared definitions for the systolic PE array front end: lane width default,
// lane slicing helper and the skew-feeder FSM state encoding.
package pe_array_pkg;

  localparam int PE_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } feed_state_e;

  // Low bit index of lane `lane` inside a packed vector of `w`-bit lanes.
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/pe_lane_delay.sv
// Fixed-depth shift chain carrying {data, valid, last} for one array row.
// Every stage clears on reset so in-flight beats are dropped, never emitted.
module pe_lane_delay
  import pe_array_pkg::*;
#(
  parameter int DEPTH  = 1,
  parameter int DATA_W = PE_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W+1:0] din,
  output logic [DATA_W+1:0] dout
);

  logic [DATA_W+1:0] chain_p [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) chain_p[k] <= '0;
    end else begin
      chain_p[0] <= din;
      for (int k = 1; k < DEPTH; k++) chain_p[k] <= chain_p[k-1];
    end
  end

  assign dout = chain_p[DEPTH-1];

endmodule

// File: rtl/pe_row_skew_feeder.sv
// Skews row-aligned vectors onto the PE array left edge: lane i lags by i+1
// cycles, and each frame is followed by a zero flush so frames never overlap.
module pe_row_skew_feeder
  import pe_array_pkg::*;
#(
  parameter int N_ROWS = 4,
  parameter int DATA_W = PE_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_ROWS*DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic [N_ROWS*DATA_W-1:0] out_data,
  output logic [N_ROWS-1:0]        out_valid,
  output logic [N_ROWS-1:0]        out_last,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int CNT_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  // Drain lasts N_ROWS-1 cycles: load N_ROWS-2 and leave when the count hits 0.
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'((N_ROWS > 1) ? N_ROWS - 2 : 0);

  feed_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept;

  assign accept = in_valid & in_ready;

  // State and drain counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE, FEED: begin
        if (accept) begin
          if (in_last) begin
            if (N_ROWS == 1) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = DRAIN;
              cnt_nxt   = DRAIN_LOAD;
            end
          end else begin
            state_nxt = FEED;
          end
        end
      end
      DRAIN: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state != DRAIN);
    busy     = (state != IDLE) | (|out_valid);
  end

  // Lane heads take the accepted beat, otherwise an all-zero bubble
  for (genvar i = 0; i < N_ROWS; i++) begin : g_lane
    localparam int LO = lane_lo(i, DATA_W);

    logic [DATA_W+1:0] head;
    logic [DATA_W+1:0] tail;

    assign head = accept ? {in_data[LO +: DATA_W], 1'b1, in_last} : '0;

    pe_lane_delay #(
      .DEPTH  (i + 1),
      .DATA_W (DATA_W)
    ) u_delay (
      .clk   (clk),
      .reset (reset),
      .din   (head),
      .dout  (tail)
    );

    assign out_data[LO +: DATA_W] = tail[DATA_W+1:2];
    assign out_valid[i]           = tail[1];
    assign out_last[i]            = tail[0];
  end

  assign frame_done = out_valid[N_ROWS-1] & out_last[N_ROWS-1];

endmodule
